layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  Parametrised, pipelined successor to the per-pixel colour mux. Composites NUM_LAYERS rectangular
//  sprite/text layers over the background gradient and drives VGA RGB. Rectangles and colour keys are
//  runtime-programmable, and indexed layers use a two-bank palette that crossfades over frames on a
//  song change. The block sits between the sprite/ROM fetch logic and the VGA DAC.
// PARAMETERS
//  NUM_LAYERS   4   layer count; lower index = higher priority
//  COORD_W      10  DrawX/DrawY width
//  IDX_W        4   palette index width; 2**IDX_W entries per bank
//  FADE_LOG2    4   crossfade length = 2**FADE_LOG2 frames
// PORTS
//  Clk          in   1               pixel clock
//  Reset_n      in   1               async active-low reset
//  DrawX,DrawY  in   COORD_W         current pixel
//  pix_valid    in   1               active-video qualifier
//  frame_start  in   1               1-cycle pulse at start of vertical blank
//  layer_rgb    in   NUM_LAYERS*24   direct colour per layer; layer i = [24i+23:24i]
//  layer_idx    in   NUM_LAYERS*IDX_W palette index per layer
//  cfg_we       in   1               config register write strobe
//  cfg_addr     in   $clog2(NUM_LAYERS)+2  {layer, word}
//  cfg_wdata    in   32              config data
//  pal_we       in   1               palette write strobe
//  pal_bank     in   1               palette bank written
//  pal_addr     in   IDX_W           palette entry written
//  pal_wdata    in   24              {R,G,B}
//  bank_sel     in   1               requested palette bank (level)
//  VGA_R,VGA_G,VGA_B out 8           registered colour
//  out_valid    out  1               pix_valid delayed 3 cycles
//  fading       out  1               high while FSM is in FADE
// BEHAVIOUR
//  Reset: every output is 0. All config = 0, so all layers are disabled. active_bank = 0, fade_k = 0, FSM IDLE.
//  Config words per layer: 0 = X {[25:16] hi, [9:0] lo}; 1 = Y (same packing);
//   2 = ctrl {[1] mode (0 direct, 1 indexed), [0] en}; 3 = key [23:0] (indexed mode compares [IDX_W-1:0]).
//  Writes land in shadow registers and are copied to live registers on frame_start. A write and frame_start
//   in the same cycle: the new value is live immediately.
//  Hit test: lo <= coord <= hi, inclusive. lo > hi = empty rectangle. A layer hits if en & inside &
//   its pixel != key. The lowest hitting index wins; with no hit the pixel is background.
//  Background: R = 8'hFF - {1'b0,X[9:3]} - 60, G = 8'hD8 - {1'b0,X[9:3]} - 60, B = 8'h9B. Arithmetic is mod 256 (wraps).
//  Pipeline, latency 3, throughput 1 pixel/clk:
//   S1 registers winner, mode, RGB/index and X.
//   S2 synchronous palette read of both banks.
//   S3 blend/select and output register.
//   Outputs update regardless of pix_valid. out_valid tracks it.
//  Palette write colliding with a read of the same entry: the read returns the old data.
//  Fade FSM, evaluated only on frame_start:
//   IDLE: if bank_sel != active_bank -> FADE, fade_k = 1.
//   FADE: fade_k++. When fade_k would reach 2**FADE_LOG2: active_bank flips, fade_k = 0 -> IDLE.
//   A bank_sel change during FADE is ignored until IDLE, then re-evaluated (bank_sel is a level).
//  Blend, indexed pixels only: c = (old*(S-k) + new*k) >> FADE_LOG2, with S = 2**FADE_LOG2,
//   old = active_bank colour, new = other bank. Intermediate width is 8+FADE_LOG2+1. Direct and
//   background pixels are never blended.
//  Reset_n low mid-fade or mid-frame: immediate return to reset state. Pipeline contents are discarded.
// STRUCTURE
//  compositor_pkg: rgb_t struct {r,g,b}; layer_mode_e; fade_state_e {IDLE, FADE}; GRAD_OFFSET = 60,
//   GRAD_SHIFT = 3, BG_R0/BG_G0/BG_B constants; function bg_color(x).
//  Sub-module palette_bank_ram: 2 banks x 2**IDX_W x 24. One write port, two synchronous read ports
//   (both banks at one address). No reset on storage.
//  Top: config/shadow registers, fade FSM, hit/priority S1, blend S3.
// TESTING
//  1 Reset, no config: X=0 -> {FF-60=C3, D8-60=9C, 9B}. X=639 -> R = FF-4F-3C = 74. Latency exactly 3
//    clk; out_valid follows pix_valid.
//  2 L0 direct, rect X 170..470 Y 330..380, key FFFFFF: X=170/470 hit, X=169/471 background. Pixel
//    FFFFFF inside the rect -> background shows through.
//  3 L0 and L1 overlap, both hit -> L0 colour. L0 pixel == key -> L1 colour. Rect lo=300, hi=200 -> never hits.
//  4 Config write mid-frame -> no change until frame_start. Write and frame_start in the same cycle -> live next pixel.
//  5 Indexed L2, bank0[3]=000000, bank1[3]=FFFFFF, FADE_LOG2=2, bank_sel 0->1: on frames
//    k=1,2,3 R = 3F, 7F, BF. Then R = FF, fading=0, active_bank=1. Toggle bank_sel mid-fade -> ignored.
//  6 Reset_n asserted during FADE: outputs 0, fading=0, active_bank=0. Palette contents persist.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types and background-gradient constants for the layer compositor.
package compositor_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        MODE_DIRECT  = 1'b0,
        MODE_INDEXED = 1'b1
    } layer_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_e;

    localparam int         GRAD_OFFSET = 60;
    localparam int         GRAD_SHIFT  = 3;
    localparam logic [7:0] BG_R0       = 8'hFF;
    localparam logic [7:0] BG_G0       = 8'hD8;
    localparam logic [7:0] BG_B        = 8'h9B;

    // xs is the already-shifted X coordinate, zero-extended to 8 bits; all math wraps mod 256
    function automatic rgb_t bg_color(input logic [7:0] xs);
        rgb_t c;
        c.r = BG_R0 - xs - 8'(GRAD_OFFSET);
        c.g = BG_G0 - xs - 8'(GRAD_OFFSET);
        c.b = BG_B;
        return c;
    endfunction

endpackage

// File: rtl/palette_bank_ram.sv
// Two-bank palette: one write port, both banks read at the same address.
// Reads are synchronous; a write to the entry being read returns the old data.
module palette_bank_ram #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wbank,
    input  logic [IDX_W-1:0] waddr,
    input  logic [23:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [23:0]      rdata0,
    output logic [23:0]      rdata1
);
    localparam int DEPTH = 2 ** IDX_W;

    logic [23:0] bank0_mem [DEPTH];
    logic [23:0] bank1_mem [DEPTH];
    logic [23:0] rd0_q, rd1_q;

    // storage and read registers carry no reset; the pipeline valid bits guard them
    always_ff @(posedge clk) begin
        if (we && !wbank) bank0_mem[waddr] <= wdata;
        if (we &&  wbank) bank1_mem[waddr] <= wdata;
        rd0_q <= bank0_mem[raddr];
        rd1_q <= bank1_mem[raddr];
    end

    assign rdata0 = rd0_q;
    assign rdata1 = rd1_q;

endmodule

// File: rtl/layer_compositor.sv
// Composites NUM_LAYERS priority rectangles over a gradient background.
// S1 hit/priority, S2 palette read, S3 blend/select into the output register.
// NUM_LAYERS is assumed to be a power of two >= 2 so the cfg layer field is dense.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COORD_W    = 10,
    parameter int IDX_W      = 4,
    parameter int FADE_LOG2  = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [COORD_W-1:0]            DrawX,
    input  logic [COORD_W-1:0]            DrawY,
    input  logic                          pix_valid,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS*24-1:0]      layer_rgb,
    input  logic [NUM_LAYERS*IDX_W-1:0]   layer_idx,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_LAYERS)+1:0] cfg_addr,
    input  logic [31:0]                   cfg_wdata,
    input  logic                          pal_we,
    input  logic                          pal_bank,
    input  logic [IDX_W-1:0]              pal_addr,
    input  logic [23:0]                   pal_wdata,
    input  logic                          bank_sel,
    output logic [7:0]                    VGA_R,
    output logic [7:0]                    VGA_G,
    output logic [7:0]                    VGA_B,
    output logic                          out_valid,
    output logic                          fading
);
    localparam int LW     = $clog2(NUM_LAYERS);
    localparam int FADE_S = 2 ** FADE_LOG2;
    localparam int BW     = 8 + FADE_LOG2 + 1;

    typedef struct packed {
        logic [COORD_W-1:0] x_lo;
        logic [COORD_W-1:0] x_hi;
        logic [COORD_W-1:0] y_lo;
        logic [COORD_W-1:0] y_hi;
        logic [23:0]        key;
        layer_mode_e        mode;
        logic               en;
    } layer_cfg_t;

    typedef struct packed {
        logic             hit;
        layer_mode_e      mode;
        rgb_t             rgb;
        logic [IDX_W-1:0] idx;
        logic [7:0]       xs;
    } s1_t;

    typedef struct packed {
        logic        hit;
        layer_mode_e mode;
        rgb_t        rgb;
        logic [7:0]  xs;
    } s2_t;

    // old*(S-k) + new*k, then divide by S; never exceeds 255*S so BW bits suffice
    function automatic logic [7:0] blend8(input logic [7:0] a, input logic [7:0] b,
                                          input logic [FADE_LOG2-1:0] k);
        logic [BW-1:0] acc;
        acc = BW'(a) * (BW'(FADE_S) - BW'(k)) + BW'(b) * BW'(k);
        return 8'(acc >> FADE_LOG2);
    endfunction

    layer_cfg_t [NUM_LAYERS-1:0] shadow_q, shadow_d, live_q, live_d;
    logic [LW-1:0]               cfg_layer;
    logic                        unused_cfg;

    fade_state_e                 state_q, state_d;
    logic [FADE_LOG2-1:0]        fade_k_q, fade_k_d;
    logic                        active_bank_q, active_bank_d;

    logic [NUM_LAYERS-1:0]       in_rect, keyed, hit;
    s1_t                         s1_q, s1_d;
    s2_t                         s2_q, s2_d;
    logic [23:0]                 pal_rd0, pal_rd1;
    rgb_t                        old_c, new_c;
    rgb_t                        vga_q, vga_d;
    logic [2:0]                  vld_pipe_q, vld_pipe_d;

    assign cfg_layer  = cfg_addr[2 +: LW];
    // bits outside the packed fields are don't-care
    assign unused_cfg = ^cfg_wdata;

    // Shadow writes; live copy on frame_start sees a same-cycle write
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we) begin
            case (cfg_addr[1:0])
                2'd0: begin
                    shadow_d[cfg_layer].x_lo = cfg_wdata[0 +: COORD_W];
                    shadow_d[cfg_layer].x_hi = cfg_wdata[16 +: COORD_W];
                end
                2'd1: begin
                    shadow_d[cfg_layer].y_lo = cfg_wdata[0 +: COORD_W];
                    shadow_d[cfg_layer].y_hi = cfg_wdata[16 +: COORD_W];
                end
                2'd2: begin
                    shadow_d[cfg_layer].mode = layer_mode_e'(cfg_wdata[1]);
                    shadow_d[cfg_layer].en   = cfg_wdata[0];
                end
                default: shadow_d[cfg_layer].key = cfg_wdata[23:0];
            endcase
        end
        live_d = frame_start ? shadow_d : live_q;
    end

    // Crossfade control, stepped once per frame
    always_comb begin
        state_d       = state_q;
        fade_k_d      = fade_k_q;
        active_bank_d = active_bank_q;
        if (frame_start) begin
            case (state_q)
                IDLE: if (bank_sel != active_bank_q) begin
                    state_d  = FADE;
                    fade_k_d = FADE_LOG2'(1);
                end
                default: if (fade_k_q == '1) begin
                    active_bank_d = ~active_bank_q;
                    fade_k_d      = '0;
                    state_d       = IDLE;
                end else begin
                    fade_k_d = fade_k_q + 1'b1;
                end
            endcase
        end
    end

    // Per-layer hit test: enabled, inside the inclusive rectangle, not the colour key
    always_comb begin
        in_rect = '0;
        keyed   = '0;
        hit     = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            in_rect[i] = (DrawX >= live_q[i].x_lo) && (DrawX <= live_q[i].x_hi) &&
                         (DrawY >= live_q[i].y_lo) && (DrawY <= live_q[i].y_hi);
            if (live_q[i].mode == MODE_INDEXED)
                keyed[i] = layer_idx[i*IDX_W +: IDX_W] == live_q[i].key[IDX_W-1:0];
            else
                keyed[i] = layer_rgb[i*24 +: 24] == live_q[i].key;
            hit[i] = live_q[i].en && in_rect[i] && !keyed[i];
        end
    end

    // S1: lowest hitting index wins, so scan from the top down and let lower indices overwrite
    always_comb begin
        s1_d = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                s1_d.hit  = 1'b1;
                s1_d.mode = live_q[i].mode;
                s1_d.rgb  = rgb_t'(layer_rgb[i*24 +: 24]);
                s1_d.idx  = layer_idx[i*IDX_W +: IDX_W];
            end
        end
        s1_d.xs = 8'(DrawX >> GRAD_SHIFT);
    end

    // S2: carry S1 forward alongside the palette read
    always_comb begin
        s2_d.hit  = s1_q.hit;
        s2_d.mode = s1_q.mode;
        s2_d.rgb  = s1_q.rgb;
        s2_d.xs   = s1_q.xs;
    end

    // S3: background, direct colour, or palette blend between active and other bank
    always_comb begin
        old_c = active_bank_q ? rgb_t'(pal_rd1) : rgb_t'(pal_rd0);
        new_c = active_bank_q ? rgb_t'(pal_rd0) : rgb_t'(pal_rd1);
        if (!s2_q.hit)
            vga_d = bg_color(s2_q.xs);
        else if (s2_q.mode == MODE_INDEXED)
            vga_d = '{r: blend8(old_c.r, new_c.r, fade_k_q),
                      g: blend8(old_c.g, new_c.g, fade_k_q),
                      b: blend8(old_c.b, new_c.b, fade_k_q)};
        else
            vga_d = s2_q.rgb;
        vld_pipe_d = {vld_pipe_q[1:0], pix_valid};
    end

    // Config and fade state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_q      <= '0;
            live_q        <= '0;
            state_q       <= IDLE;
            fade_k_q      <= '0;
            active_bank_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            live_q        <= live_d;
            state_q       <= state_d;
            fade_k_q      <= fade_k_d;
            active_bank_q <= active_bank_d;
        end
    end

    // Pipeline registers; reset discards everything in flight
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            vga_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            vga_q      <= vga_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    palette_bank_ram #(.IDX_W(IDX_W)) u_pal (
        .clk    (Clk),
        .we     (pal_we),
        .wbank  (pal_bank),
        .waddr  (pal_addr),
        .wdata  (pal_wdata),
        .raddr  (s1_q.idx),
        .rdata0 (pal_rd0),
        .rdata1 (pal_rd1)
    );

    assign VGA_R     = vga_q.r;
    assign VGA_G     = vga_q.g;
    assign VGA_B     = vga_q.b;
    assign out_valid = vld_pipe_q[2];
    assign fading    = (state_q == FADE);

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised scoreboard bench for layer_compositor (4 layers, 4-frame fade).
module tb_layer_compositor;
    localparam int NL = 4;
    localparam int FSTEPS = 4;

    logic Clk = 0, Reset_n = 0;
    logic [9:0] DrawX = 0, DrawY = 0;
    logic pix_valid = 0, frame_start = 0;
    logic [NL*24-1:0] layer_rgb = 0;
    logic [NL*4-1:0] layer_idx = 0;
    logic cfg_we = 0;
    logic [3:0] cfg_addr = 0;
    logic [31:0] cfg_wdata = 0;
    logic pal_we = 0, pal_bank = 0;
    logic [3:0] pal_addr = 0;
    logic [23:0] pal_wdata = 0;
    logic bank_sel = 0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic out_valid, fading;

    layer_compositor #(.NUM_LAYERS(NL), .COORD_W(10), .IDX_W(4), .FADE_LOG2(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .pix_valid(pix_valid), .frame_start(frame_start),
        .layer_rgb(layer_rgb), .layer_idx(layer_idx),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .pal_we(pal_we), .pal_bank(pal_bank), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .bank_sel(bank_sel), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .out_valid(out_valid), .fading(fading));

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    typedef struct { logic [23:0] rgb; int cyc; } exp_t;
    exp_t sb[$];

    // reference model state: register words as written, palette contents, fade progress
    logic [31:0] sh [NL][4];
    logic [31:0] lv [NL][4];
    logic [23:0] pal [2][16];
    int m_active = 0, m_k = 0;
    bit m_fading = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(input int x, input int y,
                                              input logic [NL*24-1:0] rgbs, input logic [NL*4-1:0] idxs);
        int xs, o, n, res;
        for (int i = 0; i < NL; i++) begin
            int xlo = int'(lv[i][0] & 1023), xhi = int'((lv[i][0] >> 16) & 1023);
            int ylo = int'(lv[i][1] & 1023), yhi = int'((lv[i][1] >> 16) & 1023);
            if (lv[i][2][0] == 1'b0) continue;
            if (x < xlo || x > xhi || y < ylo || y > yhi) continue;
            if (lv[i][2][1]) begin
                int idx = int'(idxs[i*4 +: 4]);
                if (idx == int'(lv[i][3] & 15)) continue;
                res = 0;
                for (int c = 0; c < 3; c++) begin
                    o = int'(pal[m_active][idx] >> (8*c)) & 255;
                    n = int'(pal[1-m_active][idx] >> (8*c)) & 255;
                    res = res | (((o*(FSTEPS-m_k) + n*m_k) / FSTEPS) << (8*c));
                end
                return 24'(res);
            end else begin
                if (rgbs[i*24 +: 24] == lv[i][3][23:0]) continue;
                return rgbs[i*24 +: 24];
            end
        end
        xs = x / 8;
        return {8'((255 - xs - 60) & 255), 8'((216 - xs - 60) & 255), 8'h9B};
    endfunction

    task automatic model_frame();
        for (int i = 0; i < NL; i++) for (int w = 0; w < 4; w++) lv[i][w] = sh[i][w];
        if (!m_fading) begin
            if (int'(bank_sel) != m_active) begin m_fading = 1; m_k = 1; end
        end else if (m_k + 1 == FSTEPS) begin
            m_active = 1 - m_active; m_k = 0; m_fading = 0;
        end else m_k++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) for (int w = 0; w < 4; w++) begin sh[i][w] = 0; lv[i][w] = 0; end
        m_active = 0; m_k = 0; m_fading = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        idle(3);
        frame_start = 1;
        @(posedge Clk); #1;
        frame_start = 0;
        model_frame();
        chk("fading_after_frame", 32'(fading), 32'(m_fading));
    endtask

    task automatic cfg_write(input int layer, input int word, input logic [31:0] data, input bit with_fs);
        cfg_we = 1; cfg_addr = 4'((layer << 2) | word); cfg_wdata = data; frame_start = with_fs;
        @(posedge Clk); #1;
        cfg_we = 0; frame_start = 0;
        sh[layer][word] = data;
        if (with_fs) model_frame();
    endtask

    task automatic pal_write(input int b, input int a, input logic [23:0] d);
        pal_we = 1; pal_bank = b[0]; pal_addr = 4'(a); pal_wdata = d;
        @(posedge Clk); #1;
        pal_we = 0;
        pal[b][a] = d;
    endtask

    // kmode 0: no forced keys, 1: layer 0 pixel equals its key, 2: each layer keyed 1 in 4
    task automatic pix(input int x, input int y, input int kmode = 2, input int idx2 = -1);
        logic [NL*24-1:0] rgbs;
        logic [NL*4-1:0] idxs;
        for (int i = 0; i < NL; i++) begin
            rgbs[i*24 +: 24] = 24'($urandom);
            idxs[i*4 +: 4] = 4'($urandom);
            if (kmode == 2 && $urandom_range(3) == 0) begin
                rgbs[i*24 +: 24] = lv[i][3][23:0];
                idxs[i*4 +: 4] = lv[i][3][3:0];
            end
        end
        if (kmode == 1) rgbs[23:0] = lv[0][3][23:0];
        if (idx2 >= 0) idxs[11:8] = 4'(idx2);
        DrawX = 10'(x); DrawY = 10'(y); layer_rgb = rgbs; layer_idx = idxs; pix_valid = 1;
        sb.push_back('{model_pix(x, y, rgbs, idxs), cyc + 3});
        @(posedge Clk); #1;
        pix_valid = 0;
    endtask

    // monitor: every valid output must match the scoreboard head at exactly its due cycle
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Reset_n) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL pixel_lost due=%0d now=%0d", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (out_valid) begin
                checks++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    failures++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({VGA_R, VGA_G, VGA_B} !== e.rgb) begin
                        failures++;
                        $display("FAIL pixel_rgb actual=%h required=%h cyc=%0d", {VGA_R, VGA_G, VGA_B}, e.rgb, cyc);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                checks++; failures++;
                $display("FAIL out_valid_missing actual=0 required=1 cyc=%0d", cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        idle(3);
        chk("reset_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_fading", 32'(fading), 32'h0);
        Reset_n = 1;
        idle(1);

        for (int b = 0; b < 2; b++) for (int a = 0; a < 16; a++) pal_write(b, a, 24'($urandom));
        pal_write(0, 3, 24'h000000);
        pal_write(1, 3, 24'hFFFFFF);

        // background only: gradient endpoints and random points with valid gaps
        pix(0, 0); pix(639, 479); pix(320, 240);
        for (int n = 0; n < 20; n++) begin
            pix($urandom_range(639), $urandom_range(479));
            if ($urandom_range(2) == 0) idle($urandom_range(3));
        end

        // L0 direct rectangle, inclusive edges, white key
        cfg_write(0, 0, (470 << 16) | 170, 0);
        cfg_write(0, 1, (380 << 16) | 330, 0);
        cfg_write(0, 2, 32'h1, 0);
        cfg_write(0, 3, 32'hFFFFFF, 0);
        frame();
        pix(170, 350, 0); pix(470, 350, 0); pix(169, 350, 0); pix(471, 350, 0);
        pix(300, 330, 0); pix(300, 380, 0); pix(300, 329, 0); pix(300, 381, 0);
        pix(300, 350, 1);

        // L1 overlapping L0, L3 with lo > hi (never hits)
        cfg_write(1, 0, (500 << 16) | 100, 0);
        cfg_write(1, 1, (400 << 16) | 300, 0);
        cfg_write(1, 2, 32'h1, 0);
        cfg_write(1, 3, 32'h000000, 0);
        cfg_write(3, 0, (200 << 16) | 300, 0);
        cfg_write(3, 1, (1023 << 16) | 0, 0);
        cfg_write(3, 2, 32'h1, 0);
        frame();
        pix(300, 350, 0); pix(300, 350, 1); pix(250, 10, 0); pix(250, 350, 1);

        // mid-frame write stays in shadow; write with frame_start is live next pixel
        cfg_write(0, 0, (300 << 16) | 250, 0);
        pix(200, 350, 0);
        frame();
        pix(200, 350, 0);
        cfg_write(0, 0, (470 << 16) | 170, 1);
        pix(200, 350, 0);

        // L2 indexed at top-left, key index 0
        cfg_write(2, 0, (99 << 16) | 0, 0);
        cfg_write(2, 1, (99 << 16) | 0, 0);
        cfg_write(2, 2, 32'h3, 0);
        cfg_write(2, 3, 32'h0, 0);
        frame();
        pix(50, 50, 0, 3);
        for (int n = 0; n < 150; n++) begin
            if (n % 3 == 0) pix($urandom_range(99), $urandom_range(99));
            else pix($urandom_range(639), $urandom_range(479));
        end

        // crossfade bank 0 -> 1; a bank_sel flip mid-fade is ignored
        bank_sel = 1;
        for (int f = 0; f < 4; f++) begin
            if (f == 1) bank_sel = 0;
            if (f == 2) bank_sel = 1;
            frame();
            pix(50, 50, 0, 3); pix(10, 90, 0, 3);
            for (int n = 0; n < 10; n++) pix($urandom_range(99), $urandom_range(99));
        end

        // start fading back, then reset mid-fade with pixels in flight
        bank_sel = 0;
        frame();
        pix(50, 50, 0, 3); pix(20, 20); pix(30, 30);
        Reset_n = 0;
        sb.delete();
        model_reset();
        #1;
        chk("midfade_reset_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
        chk("midfade_reset_valid", 32'(out_valid), 32'h0);
        chk("midfade_reset_fading", 32'(fading), 32'h0);
        idle(2);
        Reset_n = 1;
        idle(5);

        // palette persists; active bank back to 0 so index 3 reads black
        pix(50, 50, 0, 3);
        cfg_write(2, 0, (99 << 16) | 0, 0);
        cfg_write(2, 1, (99 << 16) | 0, 0);
        cfg_write(2, 2, 32'h3, 0);
        frame();
        pix(50, 50, 0, 3);
        for (int n = 0; n < 10; n++) pix($urandom_range(99), $urandom_range(99));

        for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge Clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
